// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the RV32I 5-stage pipeline: EX operand forwarding,
// counted load-use stalls, long-latency scoreboard and branch flush.
module hazard_ctrl_unit #(
    parameter  int NFWD     = 2,
    parameter  int RADDR_W  = 5,
    parameter  int LU_STALL = 1,
    localparam int SEL_W    = $clog2(NFWD + 1),
    localparam int NREGS    = 2 ** RADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NFWD*RADDR_W-1:0] fwd_rd,
    input  logic [NFWD-1:0]         fwd_RegWEn,
    input  logic [RADDR_W-1:0]      id_ex_rs1,
    input  logic [RADDR_W-1:0]      id_ex_rs2,
    output logic [SEL_W-1:0]        fwd_sel_A,
    output logic [SEL_W-1:0]        fwd_sel_B,
    input  logic [RADDR_W-1:0]      if_id_rs1,
    input  logic [RADDR_W-1:0]      if_id_rs2,
    input  logic                    if_id_rs1_used,
    input  logic                    if_id_rs2_used,
    input  logic [RADDR_W-1:0]      if_id_rd,
    input  logic                    if_id_RegWEn,
    input  logic [RADDR_W-1:0]      id_ex_rd,
    input  logic                    id_ex_MemRead,
    input  logic                    long_issue,
    input  logic [RADDR_W-1:0]      long_issue_rd,
    input  logic                    long_done,
    input  logic [RADDR_W-1:0]      long_done_rd,
    input  logic                    br_taken,
    output logic                    pc_stall,
    output logic                    if_id_stall,
    output logic                    id_ex_bubble,
    output logic                    if_id_flush,
    output logic                    id_ex_flush,
    output logic [NREGS-1:0]        busy,
    output logic [31:0]             stall_cnt
);

    typedef enum logic {
        IDLE,
        LU_WAIT
    } state_t;

    state_t            state;
    logic [2:0]        lu_cnt;
    logic              lu_hz;
    logic              score_hz;
    logic              stall;
    logic [NREGS-1:0]  set_mask;
    logic [NREGS-1:0]  clr_mask;
    logic [NREGS-1:0]  busy_nxt;

    // Walk oldest to youngest so the youngest matching source wins.
    always_comb begin
        fwd_sel_A = '0;
        fwd_sel_B = '0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (fwd_RegWEn[k] && fwd_rd[k*RADDR_W +: RADDR_W] != '0) begin
                if (fwd_rd[k*RADDR_W +: RADDR_W] == id_ex_rs1)
                    fwd_sel_A = SEL_W'(k + 1);
                if (fwd_rd[k*RADDR_W +: RADDR_W] == id_ex_rs2)
                    fwd_sel_B = SEL_W'(k + 1);
            end
        end
    end

    always_comb begin
        lu_hz = id_ex_MemRead && (id_ex_rd != '0) &&
                ((if_id_rs1_used && if_id_rs1 == id_ex_rd) ||
                 (if_id_rs2_used && if_id_rs2 == id_ex_rd));
        score_hz = (if_id_rs1_used && busy[if_id_rs1]) ||
                   (if_id_rs2_used && busy[if_id_rs2]) ||
                   (if_id_RegWEn && busy[if_id_rd]);
        stall = ((state == LU_WAIT) || (state == IDLE && lu_hz) ||
                 score_hz) && !br_taken;
    end

    assign pc_stall     = stall;
    assign if_id_stall  = stall;
    assign id_ex_bubble = stall;
    assign if_id_flush  = br_taken;
    assign id_ex_flush  = br_taken;

    // Set is OR-ed in after clear so a same-cycle issue/retire keeps the bit.
    always_comb begin
        set_mask    = long_issue ? (NREGS'(1) << long_issue_rd) : '0;
        clr_mask    = long_done ? (NREGS'(1) << long_done_rd) : '0;
        busy_nxt    = (busy & ~clr_mask) | set_mask;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lu_cnt    <= '0;
            busy      <= '0;
            stall_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            if (stall && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (br_taken) begin
                state  <= IDLE;
                lu_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (lu_hz && LU_STALL > 1) begin
                            state  <= LU_WAIT;
                            lu_cnt <= 3'(LU_STALL - 1);
                        end
                    end
                    LU_WAIT: begin
                        if (lu_cnt == 3'd1) begin
                            state  <= IDLE;
                            lu_cnt <= '0;
                        end else begin
                            lu_cnt <= lu_cnt - 3'd1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        lu_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (NFWD=2, RADDR_W=5, LU_STALL=2);
// expected outputs are queued with each stimulus step and checked at negedge.
module tb_hazard_ctrl_unit;

    localparam int NFWD    = 2;
    localparam int RADDR_W = 5;
    localparam int SEL_W   = 2;
    localparam int NREGS   = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NFWD*RADDR_W-1:0] fwd_rd;
    logic [NFWD-1:0]         fwd_RegWEn;
    logic [RADDR_W-1:0]      id_ex_rs1, id_ex_rs2;
    logic [SEL_W-1:0]        fwd_sel_A, fwd_sel_B;
    logic [RADDR_W-1:0]      if_id_rs1, if_id_rs2, if_id_rd;
    logic                    if_id_rs1_used, if_id_rs2_used, if_id_RegWEn;
    logic [RADDR_W-1:0]      id_ex_rd;
    logic                    id_ex_MemRead;
    logic                    long_issue, long_done;
    logic [RADDR_W-1:0]      long_issue_rd, long_done_rd;
    logic                    br_taken;
    logic                    pc_stall, if_id_stall, id_ex_bubble;
    logic                    if_id_flush, id_ex_flush;
    logic [NREGS-1:0]        busy;
    logic [31:0]             stall_cnt;

    hazard_ctrl_unit #(
        .NFWD    (NFWD),
        .RADDR_W (RADDR_W),
        .LU_STALL(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fwd_rd        (fwd_rd),
        .fwd_RegWEn    (fwd_RegWEn),
        .id_ex_rs1     (id_ex_rs1),
        .id_ex_rs2     (id_ex_rs2),
        .fwd_sel_A     (fwd_sel_A),
        .fwd_sel_B     (fwd_sel_B),
        .if_id_rs1     (if_id_rs1),
        .if_id_rs2     (if_id_rs2),
        .if_id_rs1_used(if_id_rs1_used),
        .if_id_rs2_used(if_id_rs2_used),
        .if_id_rd      (if_id_rd),
        .if_id_RegWEn  (if_id_RegWEn),
        .id_ex_rd      (id_ex_rd),
        .id_ex_MemRead (id_ex_MemRead),
        .long_issue    (long_issue),
        .long_issue_rd (long_issue_rd),
        .long_done     (long_done),
        .long_done_rd  (long_done_rd),
        .br_taken      (br_taken),
        .pc_stall      (pc_stall),
        .if_id_stall   (if_id_stall),
        .id_ex_bubble  (id_ex_bubble),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .busy          (busy),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  a;
        logic [1:0]  b;
        logic        stall;
        logic        flush;
        logic [31:0] cnt;
        logic [31:0] busy;
    } exp_t;

    exp_t  expq[$];
    string tagq[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    function automatic exp_t E(int a, int b, int st, int fl,
                               int cnt, logic [31:0] bz);
        exp_t e;
        e.a     = 2'(a);
        e.b     = 2'(b);
        e.stall = 1'(st);
        e.flush = 1'(fl);
        e.cnt   = 32'(cnt);
        e.busy  = bz;
        return e;
    endfunction

    task automatic chk(string tag, string fld,
                       logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic cyc(string tag, exp_t e);
        exp_t  x;
        string t;
        expq.push_back(e);
        tagq.push_back(tag);
        @(negedge clk);
        x = expq.pop_front();
        t = tagq.pop_front();
        chk(t, "fwd_sel_A", 32'(fwd_sel_A), 32'(x.a));
        chk(t, "fwd_sel_B", 32'(fwd_sel_B), 32'(x.b));
        chk(t, "pc_stall", 32'(pc_stall), 32'(x.stall));
        chk(t, "if_id_stall", 32'(if_id_stall), 32'(x.stall));
        chk(t, "id_ex_bubble", 32'(id_ex_bubble), 32'(x.stall));
        chk(t, "if_id_flush", 32'(if_id_flush), 32'(x.flush));
        chk(t, "id_ex_flush", 32'(id_ex_flush), 32'(x.flush));
        chk(t, "stall_cnt", stall_cnt, x.cnt);
        chk(t, "busy", busy, x.busy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        fwd_rd         = '0;
        fwd_RegWEn     = '0;
        id_ex_rs1      = '0;
        id_ex_rs2      = '0;
        if_id_rs1      = '0;
        if_id_rs2      = '0;
        if_id_rd       = '0;
        if_id_rs1_used = 1'b0;
        if_id_rs2_used = 1'b0;
        if_id_RegWEn   = 1'b0;
        id_ex_rd       = '0;
        id_ex_MemRead  = 1'b0;
        long_issue     = 1'b0;
        long_issue_rd  = '0;
        long_done      = 1'b0;
        long_done_rd   = '0;
        br_taken       = 1'b0;
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset", E(0, 0, 0, 0, 0, 32'h0));
        rst = 1'b0;

        fwd_rd = {5'd5, 5'd5}; fwd_RegWEn = 2'b11; id_ex_rs1 = 5'd5;
        cyc("fwd_young", E(1, 0, 0, 0, 0, 32'h0));
        fwd_RegWEn = 2'b10;
        cyc("fwd_old", E(2, 0, 0, 0, 0, 32'h0));
        fwd_rd = '0; fwd_RegWEn = 2'b11; id_ex_rs1 = '0; id_ex_rs2 = '0;
        cyc("fwd_x0", E(0, 0, 0, 0, 0, 32'h0));
        fwd_rd = {5'd6, 5'd4}; id_ex_rs1 = 5'd6; id_ex_rs2 = 5'd4;
        cyc("fwd_split", E(2, 1, 0, 0, 0, 32'h0));
        idle_in();

        id_ex_MemRead = 1'b1; id_ex_rd = 5'd7;
        if_id_rs1 = 5'd1; if_id_rs1_used = 1'b1;
        if_id_rs2 = 5'd7; if_id_rs2_used = 1'b1;
        cyc("lu_c0", E(0, 0, 1, 0, 0, 32'h0));
        id_ex_MemRead = 1'b0;
        cyc("lu_c1", E(0, 0, 1, 0, 1, 32'h0));
        cyc("lu_done", E(0, 0, 0, 0, 2, 32'h0));
        id_ex_MemRead = 1'b1; id_ex_rd = 5'd0;
        if_id_rs1 = 5'd0; if_id_rs2 = 5'd0;
        cyc("lu_rd0", E(0, 0, 0, 0, 2, 32'h0));
        id_ex_rd = 5'd7; if_id_rs2 = 5'd7; if_id_rs2_used = 1'b0;
        cyc("lu_unused", E(0, 0, 0, 0, 2, 32'h0));
        idle_in();

        long_issue = 1'b1; long_issue_rd = 5'd9;
        cyc("sb_issue", E(0, 0, 0, 0, 2, 32'h0));
        long_issue = 1'b0; if_id_rs1 = 5'd9; if_id_rs1_used = 1'b1;
        cyc("sb_wait0", E(0, 0, 1, 0, 2, 32'h200));
        cyc("sb_wait1", E(0, 0, 1, 0, 3, 32'h200));
        long_done = 1'b1; long_done_rd = 5'd9;
        cyc("sb_done", E(0, 0, 1, 0, 4, 32'h200));
        long_done = 1'b0;
        cyc("sb_clear", E(0, 0, 0, 0, 5, 32'h0));
        idle_in();

        long_issue = 1'b1; long_issue_rd = 5'd12; br_taken = 1'b1;
        cyc("sb_issue_br", E(0, 0, 0, 1, 5, 32'h0));
        idle_in();
        if_id_RegWEn = 1'b1; if_id_rd = 5'd12;
        cyc("sb_waw", E(0, 0, 1, 0, 5, 32'h1000));
        idle_in();
        long_done = 1'b1; long_done_rd = 5'd12;
        cyc("sb_done12", E(0, 0, 0, 0, 6, 32'h1000));
        idle_in();
        cyc("sb_clr12", E(0, 0, 0, 0, 6, 32'h0));

        long_issue = 1'b1; long_issue_rd = 5'd3;
        long_done = 1'b1; long_done_rd = 5'd3;
        cyc("sb_setclr", E(0, 0, 0, 0, 6, 32'h0));
        idle_in();
        cyc("sb_setwins", E(0, 0, 0, 0, 6, 32'h8));
        long_done = 1'b1; long_done_rd = 5'd3;
        cyc("sb_done3", E(0, 0, 0, 0, 6, 32'h8));
        idle_in();
        long_issue = 1'b1; long_issue_rd = 5'd0;
        cyc("sb_x0_issue", E(0, 0, 0, 0, 6, 32'h0));
        idle_in();
        cyc("sb_x0_ignored", E(0, 0, 0, 0, 6, 32'h0));

        id_ex_MemRead = 1'b1; id_ex_rd = 5'd7;
        if_id_rs2 = 5'd7; if_id_rs2_used = 1'b1; br_taken = 1'b1;
        cyc("br_idle", E(0, 0, 0, 1, 6, 32'h0));
        br_taken = 1'b0;
        cyc("lu2_c0", E(0, 0, 1, 0, 6, 32'h0));
        id_ex_MemRead = 1'b0; br_taken = 1'b1;
        cyc("br_luwait", E(0, 0, 0, 1, 7, 32'h0));
        br_taken = 1'b0;
        cyc("br_fsm_idle", E(0, 0, 0, 0, 7, 32'h0));
        idle_in();

        long_issue = 1'b1; long_issue_rd = 5'd20;
        cyc("rst_pre_issue", E(0, 0, 0, 0, 7, 32'h0));
        long_issue = 1'b0;
        id_ex_MemRead = 1'b1; id_ex_rd = 5'd7;
        if_id_rs2 = 5'd7; if_id_rs2_used = 1'b1;
        cyc("rst_lu_c0", E(0, 0, 1, 0, 7, 32'h100000));
        id_ex_MemRead = 1'b0; rst = 1'b1;
        cyc("rst_in_wait", E(0, 0, 1, 0, 8, 32'h100000));
        rst = 1'b0;
        if_id_rs1 = 5'd20; if_id_rs1_used = 1'b1;
        cyc("rst_after", E(0, 0, 0, 0, 0, 32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
